// File: rtl/shwr_mem_pkg.sv
// shwr_mem_pkg: shared widths, read latency and FSM states for the shower memory reader.
package shwr_mem_pkg;
    localparam int DEF_ADDR_WIDTH = 14;
    localparam int DEF_BUF_AW     = 11;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_RD_LAT     = 2;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {IDLE, ARB, READ, DRAIN, FLUSH, FIN} state_e;
endpackage

// File: rtl/shwr_rd_fifo.sv
// shwr_rd_fifo: small synchronous FIFO with clear; head word is shown on dout while count != 0.
module shwr_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         CLK,
    input  logic                         RESETN,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wr, rd;

    // a push into a full FIFO is only taken when the head leaves in the same cycle
    assign rd    = pop & (cnt_q != '0);
    assign wr    = push & ((cnt_q != CW'(DEPTH)) | rd);
    assign dout  = mem_q[rp_q];
    assign count = cnt_q;

    always_comb begin
        mem_d = mem_q;
        if (wr) mem_d[wp_q] = din;
        wp_d  = clear ? '0 : wr ? ((wp_q == PW'(DEPTH-1)) ? '0 : wp_q + 1'b1) : wp_q;
        rp_d  = clear ? '0 : rd ? ((rp_q == PW'(DEPTH-1)) ? '0 : rp_q + 1'b1) : rp_q;
        cnt_d = clear ? '0 : cnt_q + CW'(wr) - CW'(rd);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            mem_q <= '{default: '0};
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/shwr_memory_reader.sv
// shwr_memory_reader: walks a circular trace buffer over the shared B port (REQ/GNT)
// and streams the words out through a skid FIFO with valid/ready backpressure.
module shwr_memory_reader
    import shwr_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BUF_AW     = DEF_BUF_AW,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         CLK,
    input  logic                         RESETN,
    input  logic                         START,
    input  logic [ADDR_WIDTH-BUF_AW-1:0] BUF_SEL,
    input  logic [BUF_AW-1:0]            START_OFF,
    input  logic [BUF_AW:0]              LENGTH,
    input  logic                         ABORT,
    output logic                         REQ,
    input  logic                         GNT,
    output logic [ADDR_WIDTH-1:0]        ADDR_B,
    output logic                         ENA_B,
    input  logic [DATA_WIDTH-1:0]        RDATA,
    output logic [DATA_WIDTH-1:0]        DOUT,
    output logic                         DVALID,
    input  logic                         DREADY,
    output logic                         BUSY,
    output logic                         DONE
);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    state_e                       state_q, state_d;
    logic [ADDR_WIDTH-BUF_AW-1:0] sel_q, sel_d;
    logic [BUF_AW-1:0]            off_q, off_d;
    logic [BUF_AW:0]              rem_q, rem_d;
    logic [RD_LAT-1:0]            tag_q, tag_d;
    logic [1:0]                   fl_q, fl_d;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic                         req_q, req_d, ena_q, ena_d, busy_q, busy_d, done_q, done_d;
    logic [CW-1:0]                fcount;
    logic                         cnt, push, pop, flush, active;
    int                           occ;

    // an issue only counts when the grant is still held in the ENA_B cycle
    assign cnt    = ena_q & GNT;
    assign push   = tag_q[RD_LAT-1];
    assign DVALID = fcount != '0;
    assign pop    = DVALID & DREADY;
    assign active = (state_q == ARB) || (state_q == READ);
    assign flush  = ABORT & (active || (state_q == DRAIN));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        off_d   = off_q + BUF_AW'(cnt);
        rem_d   = rem_q - (BUF_AW+1)'(cnt);
        tag_d   = flush ? '0 : RD_LAT'({tag_q, cnt});
        occ     = int'(fcount) + int'(push) - int'(pop) + $countones(tag_d);
        case (state_q)
            IDLE: if (START && !ABORT) begin
                state_d = (LENGTH == '0) ? FIN : ARB;
                sel_d   = BUF_SEL;
                off_d   = START_OFF;
                rem_d   = LENGTH;
            end
            ARB, READ: state_d = flush ? FLUSH : (rem_d == '0) ? DRAIN : GNT ? READ : state_q;
            DRAIN:     state_d = flush ? FLUSH : (occ == 0) ? FIN : DRAIN;
            FLUSH:     state_d = (fl_q == 2'(RD_LAT-1)) ? FIN : FLUSH;
            FIN:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        fl_d   = (state_q == FLUSH) ? fl_q + 2'd1 : 2'd0;
        req_d  = (state_d == ARB) || (state_d == READ);
        // credit: everything already in flight or buffered plus this issue must fit the FIFO
        ena_d  = active && req_d && GNT && (occ < FIFO_DEPTH);
        addr_d = {sel_d, off_d};
        busy_d = state_d != IDLE;
        done_d = state_d == FIN;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            sel_q   <= '0;
            off_q   <= '0;
            rem_q   <= '0;
            tag_q   <= '0;
            fl_q    <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            ena_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            off_q   <= off_d;
            rem_q   <= rem_d;
            tag_q   <= tag_d;
            fl_q    <= fl_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            ena_q   <= ena_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign REQ    = req_q;
    assign ENA_B  = ena_q;
    assign ADDR_B = addr_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

    shwr_rd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
        .CLK    (CLK),
        .RESETN (RESETN),
        .push   (push & ~flush),
        .pop    (pop),
        .clear  (flush),
        .din    (RDATA),
        .dout   (DOUT),
        .count  (fcount)
    );
endmodule

// File: tb/tb_shwr_memory_reader.sv
// tb_shwr_memory_reader: directed vectors plus corner-case sequences against a
// 2-cycle-latency memory model; inputs change and outputs are checked on negedges.
module tb_shwr_memory_reader;
    localparam int RL = 2;
    localparam int FD = 4;

    logic        CLK = 1'b0, RESETN = 1'b0, START = 1'b0, ABORT = 1'b0, GNT = 1'b0, DREADY = 1'b0;
    logic [2:0]  BUF_SEL = '0;
    logic [10:0] START_OFF = '0;
    logic [11:0] LENGTH = '0;
    logic [31:0] RDATA, DOUT, p1;
    logic [13:0] ADDR_B;
    logic        REQ, ENA_B, DVALID, BUSY, DONE;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, last_xfer = 0, done_at = 0, done_cnt = 0, req_seen = 0;
    logic [13:0] iss[$];
    logic [31:0] rx[$];

    typedef struct {
        logic [2:0]  sel;
        logic [10:0] off;
        logic [11:0] len;
        logic [13:0] first;
        logic [13:0] last;
    } vec_t;
    vec_t vecs[5];

    shwr_memory_reader #(.ADDR_WIDTH(14), .BUF_AW(11), .DATA_WIDTH(32), .RD_LAT(RL), .FIFO_DEPTH(FD)) dut (
        .CLK(CLK), .RESETN(RESETN), .START(START), .BUF_SEL(BUF_SEL), .START_OFF(START_OFF),
        .LENGTH(LENGTH), .ABORT(ABORT), .REQ(REQ), .GNT(GNT), .ADDR_B(ADDR_B), .ENA_B(ENA_B),
        .RDATA(RDATA), .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_f(input logic [13:0] a);
        return 32'hC0DE0000 ^ {18'd0, a};
    endfunction

    // memory model: data appears RL cycles after a granted enable
    always @(posedge CLK) begin
        p1    <= (ENA_B && GNT) ? mem_f(ADDR_B) : 32'hDEADBEEF;
        RDATA <= p1;
    end

    always @(posedge CLK) begin
        cyc++;
        if (ENA_B && GNT) iss.push_back(ADDR_B);
        if (DVALID && DREADY) begin
            rx.push_back(DOUT);
            last_xfer = cyc;
        end
        if (DONE) begin
            done_at = cyc;
            done_cnt++;
        end
        if (REQ) req_seen++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        iss.delete();
        rx.delete();
        done_cnt = 0;
        req_seen = 0;
    endtask

    task automatic do_start(input logic [2:0] s, input logic [10:0] o, input logic [11:0] l);
        @(negedge CLK);
        BUF_SEL = s;
        START_OFF = o;
        LENGTH = l;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int k = 0;
        while (!DONE && k < budget) begin
            @(negedge CLK);
            k++;
        end
        chk({nm, " done"}, 64'(DONE), 64'd1);
        @(negedge CLK);
    endtask

    task automatic check_seq(input string nm, input logic [2:0] s, input logic [10:0] o, input int n);
        int bad_a = 0, bad_d = 0;
        logic [13:0] ea;
        for (int i = 0; i < n; i++) begin
            ea = {s, o + 11'(i)};
            if (i >= iss.size() || iss[i] !== ea) bad_a++;
            if (i >= rx.size() || rx[i] !== mem_f(ea)) bad_d++;
        end
        chk({nm, " issues"}, 64'(iss.size()), 64'(n));
        chk({nm, " words"}, 64'(rx.size()), 64'(n));
        chk({nm, " addr_errs"}, 64'(bad_a), 64'd0);
        chk({nm, " data_errs"}, 64'(bad_d), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, n_rx, stable_err, drop_hit;
        logic [31:0] d0;
        logic seen;
        vecs[0] = '{3'd2, 11'h7FE, 12'd4,    14'h17FE, 14'h1001};
        vecs[1] = '{3'd0, 11'h000, 12'd1,    14'h0000, 14'h0000};
        vecs[2] = '{3'd7, 11'h100, 12'd5,    14'h3900, 14'h3904};
        vecs[3] = '{3'd5, 11'h7FF, 12'd2,    14'h2FFF, 14'h2800};
        vecs[4] = '{3'd1, 11'h005, 12'd2048, 14'h0805, 14'h0804};

        repeat (3) @(negedge CLK);
        chk("reset ctrl", 64'({REQ, ENA_B, DVALID, BUSY, DONE}), 64'd0);
        chk("reset ADDR_B", 64'(ADDR_B), 64'd0);
        chk("reset DOUT", 64'(DOUT), 64'd0);
        RESETN = 1'b1;
        GNT = 1'b1;
        DREADY = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 5; i++) begin
            clear_mon();
            do_start(vecs[i].sel, vecs[i].off, vecs[i].len);
            wait_done($sformatf("vec%0d", i), int'(vecs[i].len) + 30);
            chk($sformatf("vec%0d done_lat", i), 64'(done_at - last_xfer), 64'd1);
            chk($sformatf("vec%0d busy_after", i), 64'(BUSY), 64'd0);
            chk($sformatf("vec%0d first", i), 64'(iss.size() > 0 ? iss[0] : 14'h3FFF), 64'(vecs[i].first));
            chk($sformatf("vec%0d last", i), 64'(iss.size() > 0 ? iss[iss.size()-1] : 14'h3FFF), 64'(vecs[i].last));
            check_seq($sformatf("vec%0d", i), vecs[i].sel, vecs[i].off, int'(vecs[i].len));
        end

        // grant withdrawn for 3 cycles while an enable is on the bus
        clear_mon();
        do_start(3'd3, 11'h010, 12'd8);
        k = 0;
        while (!(ENA_B && iss.size() >= 2) && k < 50) begin
            @(negedge CLK);
            k++;
        end
        drop_hit = int'(ENA_B);
        GNT = 1'b0;
        repeat (3) @(negedge CLK);
        GNT = 1'b1;
        chk("gnt_drop ena_at_drop", 64'(drop_hit), 64'd1);
        wait_done("gnt_drop", 60);
        check_seq("gnt_drop", 3'd3, 11'h010, 8);

        // sink stalled: issue stops at FIFO_DEPTH, head word held
        clear_mon();
        DREADY = 1'b0;
        do_start(3'd6, 11'h7FC, 12'd16);
        seen = 1'b0;
        stable_err = 0;
        d0 = '0;
        repeat (20) begin
            @(negedge CLK);
            if (DVALID && !seen) begin
                seen = 1'b1;
                d0 = DOUT;
            end else if (DVALID && DOUT !== d0) stable_err++;
        end
        chk("bp issued", 64'(iss.size()), 64'(FD));
        chk("bp ena_low", 64'(ENA_B), 64'd0);
        chk("bp dvalid", 64'(DVALID), 64'd1);
        chk("bp head", 64'(DOUT), 64'h00000000C0DE37FC);
        chk("bp stable_errs", 64'(stable_err), 64'd0);
        DREADY = 1'b1;
        wait_done("bp", 80);
        check_seq("bp", 3'd6, 11'h7FC, 16);

        // abort while the 3rd word is presented
        clear_mon();
        do_start(3'd4, 11'h200, 12'd10);
        k = 0;
        while (!(DVALID && rx.size() == 2) && k < 50) begin
            @(negedge CLK);
            k++;
        end
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        chk("abort ctrl", 64'({REQ, ENA_B, DVALID}), 64'd0);
        chk("abort busy", 64'(BUSY), 64'd1);
        chk("abort words", 64'(rx.size()), 64'd3);
        n_rx = rx.size();
        k = 1;
        while (!DONE && k < 10) begin
            @(negedge CLK);
            k++;
        end
        chk("abort done_lat", 64'(k), 64'(RL + 1));
        chk("abort no_xfer", 64'(rx.size()), 64'(n_rx));
        clear_mon();
        do_start(3'd4, 11'h300, 12'd3);
        wait_done("post_abort", 40);
        check_seq("post_abort", 3'd4, 11'h300, 3);

        // zero length: DONE in the cycle after START is sampled, no request
        clear_mon();
        do_start(3'd0, 11'h000, 12'd0);
        chk("len0 done", 64'(DONE), 64'd1);
        chk("len0 busy", 64'(BUSY), 64'd1);
        @(negedge CLK);
        chk("len0 after", 64'({BUSY, DONE}), 64'd0);
        chk("len0 req", 64'(req_seen), 64'd0);
        chk("len0 issues", 64'(iss.size()), 64'd0);

        // START while busy must not disturb the running trace
        clear_mon();
        do_start(3'd5, 11'h040, 12'd3);
        BUF_SEL = 3'd0;
        START_OFF = 11'h000;
        LENGTH = 12'd5;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_done("busy_start", 40);
        check_seq("busy_start", 3'd5, 11'h040, 3);
        repeat (5) @(negedge CLK);
        chk("busy_start done_cnt", 64'(done_cnt), 64'd1);
        chk("busy_start idle", 64'({BUSY, REQ}), 64'd0);

        // asynchronous reset in the middle of a trace
        clear_mon();
        do_start(3'd2, 11'h000, 12'd16);
        k = 0;
        while (iss.size() < 3 && k < 50) begin
            @(negedge CLK);
            k++;
        end
        chk("rst_mid active", 64'(REQ), 64'd1);
        #2 RESETN = 1'b0;
        #1;
        chk("rst_mid ctrl", 64'({REQ, ENA_B, DVALID, BUSY, DONE}), 64'd0);
        chk("rst_mid ADDR_B", 64'(ADDR_B), 64'd0);
        chk("rst_mid DOUT", 64'(DOUT), 64'd0);
        @(negedge CLK);
        RESETN = 1'b1;
        @(negedge CLK);
        clear_mon();
        do_start(3'd1, 11'h7FF, 12'd2);
        wait_done("after_rst", 40);
        check_seq("after_rst", 3'd1, 11'h7FF, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
